// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 stage sequencer and its helpers.
package fft_pkg;

  localparam int unsigned FFT_LBL_W       = 11;
  localparam int unsigned FFT_DP_LAT      = 6;
  localparam int unsigned FFT_BANK_RD_LAT = 1;
  localparam int unsigned FFT_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register pipeline; DEPTH of 0 degenerates to a wire.
module fft_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift din through DEPTH registers, cleared on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft4_stage_sequencer.sv
// Sequences one twiddle-multiply pass: issues bank reads, aligns datapath
// valid/lable, checks returned index order and strobes write-back.
module fft4_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LBL_W       = FFT_LBL_W,
  parameter int unsigned DP_LAT      = FFT_DP_LAT,
  parameter int unsigned BANK_RD_LAT = FFT_BANK_RD_LAT,
  parameter int unsigned CNT_W       = FFT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LBL_W:0]   cfg_groups,
  input  logic             hold,
  output logic             rd_en,
  output logic [LBL_W-1:0] rd_addr,
  output logic             dp_valid,
  output logic [LBL_W-1:0] dp_lable,
  input  logic             dp_ready,
  input  logic [LBL_W-1:0] dp_index,
  output logic             wr_en,
  output logic [LBL_W-1:0] wr_addr,
  output logic             busy,
  output logic             done,
  output logic             seq_err
);

  // Most groups that can legitimately be outstanding at once.
  localparam int unsigned INFL_CAP = DP_LAT + BANK_RD_LAT;

  seq_state_t       state;
  logic [LBL_W:0]   cfg_len;
  logic [LBL_W:0]   issue_cnt;
  logic [LBL_W:0]   ret_cnt;
  logic [LBL_W:0]   ret_next;
  logic [CNT_W-1:0] inflight;
  logic             armed;
  logic             ret_fire;
  logic             bad_ret;
  logic             last_issue;
  logic             accept;

  // rd_en is combinational on hold so an issue resumes in the cycle hold falls.
  assign rd_en      = (state == ISSUE) & ~hold;
  assign rd_addr    = issue_cnt[LBL_W-1:0];
  assign accept     = (state == IDLE) & start & (cfg_groups != '0);
  // Compare in LBL_W+1 bits so a full 2^LBL_W pass ends before issue_cnt wraps.
  assign last_issue = rd_en & (issue_cnt == cfg_len - 1'b1);

  assign ret_fire = dp_ready & busy;
  assign ret_next = ret_cnt + {{LBL_W{1'b0}}, ret_fire};
  assign wr_en    = ret_fire;
  assign wr_addr  = dp_index;

  // Stale readies right after reset are tolerated (armed=0); after a completed
  // pass an idle-time ready is a real protocol error.
  assign bad_ret = dp_ready &
                   ((busy & ((inflight == '0) | (dp_index != ret_cnt[LBL_W-1:0]))) |
                    (~busy & armed));

  fft_delay_line #(
    .DEPTH (BANK_RD_LAT),
    .WIDTH (LBL_W + 1)
  ) u_issue_align (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en, rd_addr}),
    .dout ({dp_valid, dp_lable})
  );

  // Pass control FSM with registered busy/done and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_len   <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_err   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bad_ret)  seq_err <= 1'b1;
      if (ret_fire) ret_cnt <= ret_next;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cfg_len   <= cfg_groups;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            seq_err   <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_en) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ret_next >= cfg_len) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          armed <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding-group counter; simultaneous issue and return cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case ({rd_en, ret_fire && (inflight != '0)})
        2'b10:   if (inflight != CNT_W'(INFL_CAP)) inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stage_sequencer.sv
// Self-checking bench for fft4_stage_sequencer with an ideal 6-cycle datapath.
module tb_fft4_stage_sequencer;

  localparam int LW  = 11;
  localparam int DPL = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW:0]   cfg_groups = '0;
  logic          hold = 1'b0;
  logic          rd_en, dp_valid, dp_ready, wr_en, busy, done, seq_err;
  logic [LW-1:0] rd_addr, dp_lable, dp_index, wr_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft4_stage_sequencer #(
    .LBL_W       (LW),
    .DP_LAT      (DPL),
    .BANK_RD_LAT (1),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_groups (cfg_groups),
    .hold       (hold),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dp_valid   (dp_valid),
    .dp_lable   (dp_lable),
    .dp_ready   (dp_ready),
    .dp_index   (dp_index),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done),
    .seq_err    (seq_err)
  );

  // Ideal datapath: ready/index appear DPL cycles after valid/lable; not reset.
  logic [DPL-1:0] pv = '0;
  logic [LW-1:0]  pl [DPL];
  logic           corrupt_first = 1'b0;

  always @(posedge clk) begin
    pv <= {pv[DPL-2:0], dp_valid};
    pl[0] <= dp_lable;
    for (int i = DPL - 1; i > 0; i--) pl[i] <= pl[i-1];
  end

  assign dp_ready = pv[DPL-1];
  assign dp_index = (corrupt_first && pl[DPL-1] == '0) ? 11'd1 : pl[DPL-1];

  // Scoreboard and event monitor.
  int            exp_q[$];
  int            exp_rd, rd_cnt, wr_cnt, done_cnt;
  int            first_rd_cyc, first_dv_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
  logic [LW-1:0] last_rd, first_dl;

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      checks++;
      if (rd_addr !== exp_rd[LW-1:0]) begin
        failures++;
        $display("FAIL rd_addr_seq: got %0d expected %0d", rd_addr, exp_rd);
      end
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd = rd_addr;
      exp_rd++;
      rd_cnt++;
    end
    if (dp_valid === 1'b1 && first_dv_cyc < 0) begin
      first_dv_cyc = cyc;
      first_dl = dp_lable;
    end
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got wr_addr=%0d expected no write", wr_addr);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (wr_addr !== e[LW-1:0]) begin
          failures++;
          $display("FAIL wr_addr: got %0d expected %0d", wr_addr, e);
        end
      end
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    exp_q.delete();
    exp_rd = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    first_rd_cyc = -1; first_dv_cyc = -1; first_wr_cyc = -1;
    last_wr_cyc = -1; done_cyc = -1;
    last_rd = '0; first_dl = '1;
  endtask

  // Pulse start; on return we are just after the accepting edge (cycle 1).
  task automatic start_pass(input int n, input bit corrupt);
    clear_stats();
    for (int i = 0; i < n; i++) exp_q.push_back((corrupt && i == 0) ? 1 : i);
    @(negedge clk);
    cfg_groups = n[LW:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  function automatic int rel(input int c);
    return c - t0 + 1;
  endfunction

  task automatic wait_done(input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt > 0) break;
    end
    repeat (4) tick();
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL %s_missing_writes: got %0d outstanding expected 0", tag, exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after: got %b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    clear_stats();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy, rd_en, done, seq_err, wr_en, dp_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {busy, rd_en, done, seq_err, wr_en, dp_valid});
    end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    start_pass(4, 1'b0);
    wait_done(100, "basic");
    checks++;
    if (rel(first_rd_cyc) !== 1) begin
      failures++; $display("FAIL basic_first_rd: got cycle %0d expected 1", rel(first_rd_cyc));
    end
    checks++;
    if (rel(first_dv_cyc) !== 2 || first_dl !== '0) begin
      failures++;
      $display("FAIL basic_first_valid: got cycle %0d lable %0d expected cycle 2 lable 0",
               rel(first_dv_cyc), first_dl);
    end
    checks++;
    if (rel(first_wr_cyc) !== 8 || rel(last_wr_cyc) !== 11) begin
      failures++;
      $display("FAIL basic_wr_window: got %0d..%0d expected 8..11",
               rel(first_wr_cyc), rel(last_wr_cyc));
    end
    checks++;
    if (rel(done_cyc) !== 12) begin
      failures++; $display("FAIL basic_done_cycle: got %0d expected 12", rel(done_cyc));
    end
    checks++;
    if (rd_cnt !== 4 || wr_cnt !== 4 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_counts: got rd=%0d wr=%0d err=%b expected 4 4 0", rd_cnt, wr_cnt, seq_err);
    end
  endtask

  task automatic test_hold();
    bit saw_rd;
    saw_rd = 1'b0;
    start_pass(8, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 hold = 1'b1;
    repeat (3) begin
      tick();
      if (rd_en !== 1'b0) saw_rd = 1'b1;
    end
    checks++;
    if (saw_rd !== 1'b0 || rd_cnt !== 2) begin
      failures++;
      $display("FAIL hold_pause: got rd_during_hold=%b rd_cnt=%0d expected 0 2", saw_rd, rd_cnt);
    end
    @(posedge clk);
    #1 hold = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 11'd2) begin
      failures++;
      $display("FAIL hold_resume: got rd_en=%b addr=%0d expected 1 2", rd_en, rd_addr);
    end
    wait_done(100, "hold");
    checks++;
    if (rd_cnt !== 8 || wr_cnt !== 8 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL hold_counts: got rd=%0d wr=%0d err=%b expected 8 8 0", rd_cnt, wr_cnt, seq_err);
    end
  endtask

  task automatic test_seq_err();
    corrupt_first = 1'b1;
    start_pass(4, 1'b1);
    for (int i = 0; i < 50 && wr_cnt == 0; i++) tick();
    tick();
    checks++;
    if (seq_err !== 1'b1) begin
      failures++; $display("FAIL err_set: got %b expected 1", seq_err);
    end
    wait_done(100, "err");
    checks++;
    if (seq_err !== 1'b1) begin
      failures++; $display("FAIL err_sticky: got %b expected 1", seq_err);
    end
    corrupt_first = 1'b0;
    start_pass(2, 1'b0);
    tick();
    checks++;
    if (seq_err !== 1'b0) begin
      failures++; $display("FAIL err_clear_on_start: got %b expected 0", seq_err);
    end
    wait_done(100, "err_clean");
    checks++;
    if (seq_err !== 1'b0 || wr_cnt !== 2) begin
      failures++;
      $display("FAIL err_clean_pass: got err=%b wr=%0d expected 0 2", seq_err, wr_cnt);
    end
  endtask

  task automatic test_zero();
    bit active;
    active = 1'b0;
    start_pass(0, 1'b0);
    repeat (30) begin
      tick();
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) active = 1'b1;
    end
    checks++;
    if (active !== 1'b0 || rd_cnt !== 0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL zero_ignored: got active=%b rd=%0d done=%0d expected 0 0 0",
               active, rd_cnt, done_cnt);
    end
  endtask

  task automatic test_full();
    start_pass(2048, 1'b0);
    wait_done(2300, "full");
    checks++;
    if (rd_cnt !== 2048 || wr_cnt !== 2048) begin
      failures++;
      $display("FAIL full_counts: got rd=%0d wr=%0d expected 2048 2048", rd_cnt, wr_cnt);
    end
    checks++;
    if (last_rd !== 11'd2047 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL full_last: got last_rd=%0d err=%b expected 2047 0", last_rd, seq_err);
    end
  endtask

  task automatic test_reset_mid();
    start_pass(16, 1'b0);
    repeat (5) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
    #1;
    checks++;
    if ({busy, rd_en, dp_valid, wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL midrst_async: got %b expected 0000", {busy, rd_en, dp_valid, wr_en});
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    checks++;
    if (wr_cnt !== 0 || seq_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stale: got wr=%0d err=%b busy=%b expected 0 0 0", wr_cnt, seq_err, busy);
    end
    start_pass(3, 1'b0);
    wait_done(100, "midrst_next");
    checks++;
    if (wr_cnt !== 3 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_next_pass: got wr=%0d err=%b expected 3 0", wr_cnt, seq_err);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_seq_err();
    test_zero();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
